// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timekeeping core.
// Holds the FSM state encoding, BCD digit widths and default digit limits.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_ADJ  = 2'd2
    } state_t;

    localparam int TENS_W         = 3;
    localparam int UNITS_W        = 4;
    localparam int MAX_TENS_DFLT  = 5;
    localparam int MAX_UNITS_DFLT = 9;

endpackage

// File: rtl/bcd_mod60.sv
// One BCD tens:units field counting 00..MAX_TENS:MAX_UNITS with clear and increment.
// wrap is combinational so a carry reaches the next field on the same clock edge.
module bcd_mod60
    import stopwatch_pkg::*;
#(
    parameter int MAX_TENS  = MAX_TENS_DFLT,
    parameter int MAX_UNITS = MAX_UNITS_DFLT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               inc,
    input  logic               clr,
    output logic [TENS_W-1:0]  tens,
    output logic [UNITS_W-1:0] units,
    output logic               wrap
);

    localparam logic [TENS_W-1:0]  TENS_TOP  = TENS_W'(MAX_TENS);
    localparam logic [UNITS_W-1:0] UNITS_TOP = UNITS_W'(MAX_UNITS);

    logic units_top;
    logic tens_top;

    // >= rather than == keeps the digits in range even if a bad value ever appears
    assign units_top = (units >= UNITS_TOP);
    assign tens_top  = (tens >= TENS_TOP);
    assign wrap      = inc & ~clr & units_top & tens_top;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens  <= '0;
            units <= '0;
        end else if (clr) begin
            tens  <= '0;
            units <= '0;
        end else if (inc) begin
            if (units_top) begin
                units <= '0;
                tens  <= tens_top ? '0 : tens + 1'b1;
            end else begin
                units <= units + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// BCD mm:ss stopwatch core with run/stop, clear and per-field adjust.
// Optional lap hold is built when STOPWATCH_LAP_EN is defined.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX_TENS  = MAX_TENS_DFLT,
    parameter int MAX_UNITS = MAX_UNITS_DFLT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick_1hz,
    input  logic               tick_2hz,
    input  logic               pause,
    input  logic               clear,
    input  logic               adj,
    input  logic               sel,
    input  logic               lap,
    output logic [TENS_W-1:0]  minhv,
    output logic [UNITS_W-1:0] minlv,
    output logic [TENS_W-1:0]  sechv,
    output logic [UNITS_W-1:0] seclv,
    output logic               running
);

    state_t state;
    state_t state_next;
    logic   run_flag;
    logic   run_flag_next;
    logic   pause_q;
    logic   pause_edge;

    logic   run_tick;
    logic   adj_step;
    logic   sec_inc;
    logic   min_inc;
    logic   sec_wrap;
    logic   min_wrap;

    logic [TENS_W-1:0]  sec_tens;
    logic [UNITS_W-1:0] sec_units;
    logic [TENS_W-1:0]  min_tens;
    logic [UNITS_W-1:0] min_units;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_STOP;
            run_flag <= 1'b0;
            pause_q  <= 1'b0;
        end else begin
            state    <= state_next;
            run_flag <= run_flag_next;
            pause_q  <= pause;
        end
    end

    always_comb begin
        pause_edge    = pause & ~pause_q;
        run_flag_next = run_flag ^ pause_edge;
        state_next    = ST_STOP;
        if (adj) begin
            state_next = ST_ADJ;
        end else if (run_flag_next) begin
            state_next = ST_RUN;
        end
    end

    assign running = (state == ST_RUN);

    // Decisions use the live adj and the pre-toggle run_flag, so a tick coinciding
    // with adj rising is dropped and a tick coinciding with a pause edge still counts.
    assign run_tick = tick_1hz & ~adj & run_flag;
    assign adj_step = tick_2hz & adj;
    assign sec_inc  = run_tick | (adj_step & ~sel);
    assign min_inc  = (run_tick & sec_wrap) | (adj_step & sel);

    bcd_mod60 #(
        .MAX_TENS  (MAX_TENS),
        .MAX_UNITS (MAX_UNITS)
    ) u_sec (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (sec_inc),
        .clr   (clear),
        .tens  (sec_tens),
        .units (sec_units),
        .wrap  (sec_wrap)
    );

    bcd_mod60 #(
        .MAX_TENS  (MAX_TENS),
        .MAX_UNITS (MAX_UNITS)
    ) u_min (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (min_inc),
        .clr   (clear),
        .tens  (min_tens),
        .units (min_units),
        .wrap  (min_wrap)
    );

    logic unused_min_wrap;
    assign unused_min_wrap = min_wrap;

`ifdef STOPWATCH_LAP_EN
    logic               lap_q;
    logic               hold;
    logic [TENS_W-1:0]  snap_min_tens;
    logic [UNITS_W-1:0] snap_min_units;
    logic [TENS_W-1:0]  snap_sec_tens;
    logic [UNITS_W-1:0] snap_sec_units;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_q          <= 1'b0;
            hold           <= 1'b0;
            snap_min_tens  <= '0;
            snap_min_units <= '0;
            snap_sec_tens  <= '0;
            snap_sec_units <= '0;
        end else begin
            lap_q <= lap;
            if (clear) begin
                hold <= 1'b0;
            end else if (lap & ~lap_q) begin
                hold <= ~hold;
                if (!hold) begin
                    snap_min_tens  <= min_tens;
                    snap_min_units <= min_units;
                    snap_sec_tens  <= sec_tens;
                    snap_sec_units <= sec_units;
                end
            end
        end
    end

    assign minhv = hold ? snap_min_tens  : min_tens;
    assign minlv = hold ? snap_min_units : min_units;
    assign sechv = hold ? snap_sec_tens  : sec_tens;
    assign seclv = hold ? snap_sec_units : sec_units;
`else
    logic unused_lap;
    assign unused_lap = lap;

    assign minhv = min_tens;
    assign minlv = min_units;
    assign sechv = sec_tens;
    assign seclv = sec_units;
`endif

endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

Timekeeping core of the stopwatch: a BCD mm:ss counter from 00:00 to 59:59 with pause, clear and field-adjust controls. It sits directly upstream of the four-digit multiplexed display stage. It drives that stage's `minhv`/`minlv`/`sechv`/`seclv` digit inputs. All control inputs arrive already debounced and synchronous to `clk`, and the 1 Hz and 2 Hz single-cycle enables come from the shared clock-divider.

## Interface
Parameters:
- `MAX_TENS`, default 5: highest tens digit for both fields, giving a modulus of 60.
- `MAX_UNITS`, default 9: highest units digit for both fields.

Ports:
- `clk`, input, 1: system clock. This is the only clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `tick_1hz`, input, 1: single-cycle enable for normal counting.
- `tick_2hz`, input, 1: single-cycle enable for adjust-mode stepping.
- `pause`, input, 1: debounced level; each rising edge toggles run/stop.
- `clear`, input, 1: synchronous clear to 00:00.
- `adj`, input, 1: level; high selects adjust mode.
- `sel`, input, 1: adjust field; 0 selects seconds, 1 selects minutes.
- `lap`, input, 1: debounced level; each rising edge toggles display hold. Used only with `STOPWATCH_LAP_EN`.
- `minhv`, output, 3: minutes tens digit, 0 to 5.
- `minlv`, output, 4: minutes units digit, 0 to 9.
- `sechv`, output, 3: seconds tens digit, 0 to 5.
- `seclv`, output, 4: seconds units digit, 0 to 9.
- `running`, output, 1: high when in ST_RUN.

## Operation
- **States:** the FSM has three states, ST_STOP, ST_RUN and ST_ADJ. A `run_flag` register holds the run/stop choice across ST_ADJ.
- **Pause edge detect:** the block registers `pause` as `pause_q`; a toggle event is `pause & ~pause_q`. A toggle event inverts `run_flag`.
- **Transitions:**
  - If `adj=1`, the FSM enters ST_ADJ.
  - If `adj=0`, the FSM is in ST_RUN when `run_flag=1`, otherwise ST_STOP.
  - Pause edges during ST_ADJ still toggle `run_flag`, so the state on exit from ST_ADJ reflects the toggled value.
- **ST_RUN:** on `tick_1hz` the full mm:ss value increments.
  - `seclv` 9→0 carries into `sechv`.
  - `sechv`:`seclv` 5:9 → 0:0 carries into `minlv`.
  - 59:59 → 00:00 wraps, with no overflow flag.
- **ST_STOP:** the digits hold.
- **ST_ADJ:** `tick_1hz` is ignored. On `tick_2hz` only the field chosen by `sel` increments, modulo 60.
  - There is no carry between fields: seconds 59→00 leaves the minutes unchanged.
  - The unselected field holds.
- **Priority each cycle, highest first:** `rst_n`, then `clear`, then adjust step, then run tick. `clear` sets all digits to 0 and does not change `run_flag`.
- **Simultaneous events:**
  - A pause edge and `tick_1hz` in the same cycle: the tick is evaluated with the old `run_flag`.
  - `adj` rising and `tick_1hz` in the same cycle: the block is in ST_ADJ and the tick is dropped.
- **Digit range:** digit registers never hold values above their maximum, even when the step and the wrap fall on the same cycle.

## Timing
- **Reset values:** all digits 0, `run_flag=0` (ST_STOP), `running=0`, `pause_q=0`, lap hold off.
- **Outputs:** all outputs are registered.
- **Tick latency:** a tick sampled at clock edge N produces the new digits after edge N, so they are visible in cycle N+1.
- **Pause latency:** a pause edge sampled at edge N updates `running` after edge N.
- **Clear latency:** `clear` high at edge N gives 00:00 after edge N. If `clear` is held high, the value stays at 00:00.
- **Reset mid-count:** asserting `rst_n` low forces the reset values immediately, without waiting for `clk`. Counting resumes on the first `tick_1hz` after `rst_n` rises, and only if the FSM has been put into ST_RUN by a pause edge.

## Configuration
- **`STOPWATCH_LAP_EN` defined:** `lap` is edge-detected in the same way as `pause`, and each edge toggles `hold`.
  - While `hold=1`, the outputs show snapshot registers captured at the toggle edge, while the internal count continues.
  - `clear` forces `hold=0`.
  - `hold` resets to 0.
- **`STOPWATCH_LAP_EN` not defined:** the `lap` port exists but is ignored. The outputs always equal the internal digits, and no snapshot registers are built.

## Structure
- **Package `stopwatch_pkg`:** holds the state enum (ST_STOP, ST_RUN, ST_ADJ), the digit widths (3 and 4), and the `MAX_TENS`/`MAX_UNITS` constants.
- **Sub-module `bcd_mod60`:** one BCD tens:units pair with inputs `inc` and `clr`, and outputs `tens`, `units` and a `wrap` pulse.
  - The block instantiates it twice: once for seconds and once for minutes.
  - In ST_RUN, the seconds instance's `wrap` drives the minutes instance's `inc`. In ST_ADJ, that connection is gated off.

## Test plan
- **Reset and count:** release reset, pulse `pause`, then apply 75 `tick_1hz` pulses. The outputs must read 01:15 and `running` must be 1.
- **Wrap:** from 59:58 in ST_RUN, apply 2 ticks. The outputs must read 00:00 with no other side effect.
- **Adjust:** with `adj=1` and `sel=0`, starting from 12:58, apply 3 `tick_2hz` pulses. The outputs must read 12:01. Then with `sel=1`, apply 1 `tick_2hz` pulse. The outputs must read 13:01, and interleaved `tick_1hz` pulses must be ignored.
- **Simultaneous events and clear:**
  - From ST_RUN at 00:09, apply a pause edge and `tick_1hz` in the same cycle. The outputs must read 00:10 with `running=0`.
  - Then apply `clear` and `tick_1hz` together. The outputs must read 00:00.
- **Asynchronous reset mid-count:** drive `rst_n` low between clock edges at 03:27. The outputs must go to 00:00 and `running` to 0 before the next edge.
- **Lap (`STOPWATCH_LAP_EN` defined):** apply a lap edge at 00:05, then 4 ticks. The outputs must stay at 00:05. A second lap edge must show 00:09.
